ram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sits directly upstream of `ram_bank` and turns it into a first-in-first-out buffer with valid/ready handshakes on both sides. It owns the write/read pointers, occupancy and flow control, and drives the bank's `en`/`we`/`re`/`addr_w`/`d_w`/`addr_r` ports. The bank's registered read output is the FIFO's output stage, so `m_data` is taken straight from the bank. Producers push words on the `s_*` side; the downstream consumer pops them on the `m_*` side.

---
 rtl/ram_fifo_pkg.sv | 15 +
 rtl/ram_fifo_ctrl_wrap_ptr.sv | 46 ++++
 rtl/ram_fifo_ctrl.sv | 108 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_pkg
// Description : Default geometry of the FIFO bank. It is shared by
//               ram_fifo_ctrl and ram_bank so that both agree on it.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_fifo_pkg;

    localparam int DEF_ADDR_BIT   = 3;
    localparam int DEF_DATA_BIT   = 16;
    localparam int DEF_MEM_HEIGHT = 8;

endpackage : ram_fifo_pkg
`default_nettype wire

// File: rtl/ram_fifo_ctrl_wrap_ptr.sv
`default_nettype none
// ============================================================================
// Module      : wrap_ptr
// Description : Bank address pointer. It advances on inc and wraps from
//               MEM_HEIGHT-1 back to 0 by compare, so non-power-of-2 depths
//               are supported.
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_ptr
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_BIT   = DEF_ADDR_BIT,
    parameter int MEM_HEIGHT = DEF_MEM_HEIGHT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    output logic [ADDR_BIT-1:0] ptr
);

    localparam logic [ADDR_BIT-1:0] LAST_PTR = ADDR_BIT'(MEM_HEIGHT - 1);

    logic [ADDR_BIT-1:0] ptr_q;
    logic [ADDR_BIT-1:0] ptr_d;

    // Next pointer: hold, increment, or wrap to zero after the last row
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == LAST_PTR) ? '0 : ptr_q + 1'b1;
        end
    end

    // Pointer register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule : wrap_ptr
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_ctrl
// Description : Valid/ready FIFO controller in front of ram_bank. The bank's
//               registered read port is the output stage, so there is no
//               bypass. Capacity is MEM_HEIGHT words in the bank plus one
//               word in the output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_BIT   = DEF_ADDR_BIT,
    parameter int DATA_BIT   = DEF_DATA_BIT,
    parameter int MEM_HEIGHT = DEF_MEM_HEIGHT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_BIT-1:0] s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_BIT-1:0] m_data,
    output logic [ADDR_BIT:0]   count,
    output logic                ram_en,
    output logic                ram_we,
    output logic                ram_re,
    output logic [ADDR_BIT-1:0] ram_addr_w,
    output logic [ADDR_BIT-1:0] ram_addr_r,
    output logic [DATA_BIT-1:0] ram_d_w,
    input  logic [DATA_BIT-1:0] ram_d_r
);

    localparam logic [ADDR_BIT:0] FULL_CNT = (ADDR_BIT + 1)'(MEM_HEIGHT);

    logic [ADDR_BIT:0] ram_cnt_q;
    logic [ADDR_BIT:0] ram_cnt_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic              wr;
    logic              rd;

    // Flow control. Both strobes are gated by rst_n so that the bank is idle
    // during reset, even before the state registers have been cleared.
    assign s_ready = rst_n & (ram_cnt_q != FULL_CNT);
    assign wr      = s_valid & s_ready;
    assign rd      = rst_n & (ram_cnt_q != '0) & (~out_valid_q | m_ready);

    wrap_ptr #(
        .ADDR_BIT   (ADDR_BIT),
        .MEM_HEIGHT (MEM_HEIGHT)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr),
        .ptr   (ram_addr_w)
    );

    wrap_ptr #(
        .ADDR_BIT   (ADDR_BIT),
        .MEM_HEIGHT (MEM_HEIGHT)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd),
        .ptr   (ram_addr_r)
    );

    // Next bank occupancy and output-stage state. A read reloads the output
    // stage; a pop with no reload empties it.
    always_comb begin
        ram_cnt_d = ram_cnt_q;
        case ({wr, rd})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        out_valid_d = out_valid_q;
        if (rd) begin
            out_valid_d = 1'b1;
        end else if (m_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Occupancy and output-stage registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ram_we  = wr;
    assign ram_re  = rd;
    assign ram_en  = wr | rd;
    assign ram_d_w = s_data;
    assign m_data  = ram_d_r;
    assign m_valid = out_valid_q;
    assign count   = ram_cnt_q + (ADDR_BIT + 1)'(out_valid_q);

endmodule : ram_fifo_ctrl
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_fifo_ctrl
// Description : Self-checking bench for ram_fifo_ctrl with a behavioural bank
//               and a queue-based FIFO reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [AW:0]   count;
    logic          ram_en;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_addr_w;
    logic [AW-1:0] ram_addr_r;
    logic [DW-1:0] ram_d_w;
    logic [DW-1:0] ram_d_r = '0;

    logic [DW-1:0] mem [DEPTH];

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: every word held, oldest first, plus output-stage flag
    logic [DW-1:0] q[$];
    bit            ov = 1'b0;
    bit            known = 1'b0;
    int            wr_n = 0;
    int            rd_n = 0;
    bit            last_acc;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(
        .ADDR_BIT   (AW),
        .DATA_BIT   (DW),
        .MEM_HEIGHT (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .count      (count),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_re     (ram_re),
        .ram_addr_w (ram_addr_w),
        .ram_addr_r (ram_addr_r),
        .ram_d_w    (ram_d_w),
        .ram_d_r    (ram_d_r)
    );

    // Behavioural bank: synchronous write, registered read that holds otherwise
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr_w] <= ram_d_w;
        if (ram_en && ram_re) ram_d_r <= mem[ram_addr_r];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance
    task automatic step(input bit rv, input bit sv, input logic [DW-1:0] sd, input bit mr);
        int  bank;
        bit  e_rdy;
        bit  e_wr;
        bit  e_rd;
        rst_n   = rv;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
        bank  = q.size() - int'(ov);
        e_rdy = rv && known && (bank != DEPTH);
        e_wr  = sv && e_rdy;
        e_rd  = rv && known && (bank != 0) && (!ov || mr);
        chk("s_ready", 32'(s_ready), 32'(e_rdy));
        chk("ram_we",  32'(ram_we),  32'(e_wr));
        chk("ram_re",  32'(ram_re),  32'(e_rd));
        chk("ram_en",  32'(ram_en),  32'(e_wr | e_rd));
        if (known) begin
            chk("m_valid", 32'(m_valid), 32'(ov));
            chk("count",   32'(count),   32'(q.size()));
            if (ov) chk("m_data", 32'(m_data), 32'(q[0]));
        end
        if (e_wr) begin
            chk("addr_w", 32'(ram_addr_w), 32'(wr_n % DEPTH));
            chk("d_w",    32'(ram_d_w),    32'(sd));
        end
        if (e_rd) chk("addr_r", 32'(ram_addr_r), 32'(rd_n % DEPTH));
        last_acc = e_wr;
        @(posedge clk);
        if (!rv) begin
            q.delete();
            ov    = 1'b0;
            wr_n  = 0;
            rd_n  = 0;
            known = 1'b1;
        end else begin
            if (ov && mr) void'(q.pop_front());
            if (e_wr) begin
                q.push_back(sd);
                wr_n++;
            end
            if (e_rd) rd_n++;
            ov = e_rd ? 1'b1 : (mr ? 1'b0 : ov);
        end
        @(negedge clk);
    endtask

    logic [DW-1:0] nd;

    initial begin
        @(negedge clk);

        // Reset: two cycles low, then s_ready must rise on the first cycle out
        step(0, 0, '0, 0);
        step(0, 1, 16'hFFFF, 1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        step(1, 0, '0, 0);

        // Single word: visible two cycles after the accept, then held
        step(1, 1, 16'hA5A5, 0);
        step(1, 0, '0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, '0, 0);
        chk("single_data", 32'(m_data), 32'hA5A5);
        for (int i = 0; i < 4; i++) step(1, 0, '0, 1);

        // Fill and drain: nine accepted, the tenth held off until a pop
        nd = 16'h0001;
        for (int i = 0; i < 14; i++) begin
            step(1, 1, nd, 0);
            if (last_acc) nd++;
        end
        chk("fill_count", 32'(count), 32'd9);
        chk("fill_next", 32'(nd), 32'h000A);
        for (int i = 0; i < 20; i++) begin
            step(1, nd <= 16'h000A, nd, 1);
            if (last_acc) nd++;
        end
        chk("drain_count", 32'(count), 32'd0);

        // Streaming: 20 words at full rate, both pointers wrap twice
        nd = 16'h0100;
        for (int i = 0; i < 26; i++) begin
            step(1, nd < 16'h0114, nd, 1);
            if (last_acc) nd++;
        end
        chk("stream_count", 32'(count), 32'd0);

        // Full with simultaneous push/pop: only the pop happens that cycle
        nd = 16'h0200;
        for (int i = 0; i < 12; i++) begin
            step(1, 1, nd, 0);
            if (last_acc) nd++;
        end
        step(1, 1, nd, 1);
        if (last_acc) nd++;
        step(1, 1, nd, 0);
        if (last_acc) nd++;
        chk("full_refill", 32'(count), 32'd9);
        for (int i = 0; i < 12; i++) step(1, 0, '0, 1);

        // Reset mid-stream at five words, then one fresh word
        for (int i = 0; i < 5; i++) step(1, 1, 16'h0300 + 16'(i), 0);
        step(1, 0, '0, 0);
        chk("mid_count", 32'(count), 32'd5);
        step(0, 0, '0, 0);
        chk("mid_rst_count", 32'(count), 32'd0);
        step(1, 1, 16'h1234, 0);
        for (int i = 0; i < 4; i++) step(1, 0, '0, 0);
        chk("mid_word", 32'(m_data), 32'h1234);
        for (int i = 0; i < 4; i++) step(1, 0, '0, 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 64) != 0, ($urandom % 4) != 0,
                 DW'($urandom), ($urandom % 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_ram_fifo_ctrl
`default_nettype wire
